teclado_matricial: RTL
======================

// Module: teclado_matricial
// PURPOSE
//   4x4 matrix keypad scanner feeding the door-lock front end (key_valid/key_code consumed by PIN assembly).
//   Drives one column low at a time, synchronises and debounces the row inputs, and emits one
//   single-cycle key_valid pulse with a 4-bit key_code per accepted press.
//   Holding a key does not produce repeats.
// PARAMETERS
//   SCAN_CYCLES      1000    clk cycles each column is held low before its rows are sampled
//   DEBOUNCE_CYCLES  50000   consecutive stable cycles required for both press and release
//   BIP_CYCLES       5000000 length of key_bip pulse (used only with KEYPAD_BIP_EN)
// PORTS
//   clk        in   1  system clock
//   rst        in   1  asynchronous, active-low reset
//   row_in     in   4  keypad rows, active-low, pulled up, asynchronous to clk
//   col_out    out  4  keypad column drive, active-low, exactly one bit low
//   key_valid  out  1  one-cycle pulse: key_code is valid
//   key_code   out  4  accepted key; held until the next accepted key
//   key_bip    out  1  key-press feedback pulse (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst=0, async): state S_SCAN; col index 0; col_out=4'b1110; key_valid=0; key_code=4'h0;
//     key_bip=0; counters 0; row synchroniser flops 4'hF.
//   Row inputs pass a 2-FF synchroniser (rows_s). All decisions use rows_s. Adds 2 cycles latency.
//   Key map: row r (0..3) by col c (0..3) is
//     r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
//   Codes: digits=value; A..D=4'hA..4'hD; *=4'hE; #=4'hF.
//   FSM:
//   S_SCAN
//     - Dwell counter runs 0..SCAN_CYCLES-1 on the current column.
//     - At the last dwell cycle: rows_s with exactly one 0 -> latch row/col, clear debounce counter,
//       go S_DEBOUNCE, column stays driven.
//     - Otherwise (none low, or >=2 low = multi-key/ghost, ignored) -> advance column 0>1>2>3>0
//       and restart dwell.
//   S_DEBOUNCE
//     - Each cycle rows_s equals the latched pattern: counter++.
//     - Any mismatch: go S_SCAN, advance column, no output.
//     - When counter reaches DEBOUNCE_CYCLES-1 with a match: next edge key_valid=1 for one cycle,
//       key_code=map(row,col); go S_HELD.
//   S_HELD
//     - Column held; waits for rows_s==4'hF for DEBOUNCE_CYCLES consecutive cycles.
//     - Any low row restarts the count.
//     - Then go S_SCAN on the next column. No outputs while held; other keys are ignored.
//   Counters: $clog2(max param) bits; compare with ==, no wrap beyond the terminal value.
//   key_valid is never high on two consecutive cycles. Minimum spacing between pulses is
//     2*DEBOUNCE_CYCLES.
//   Press-to-pulse latency: <= 4*SCAN_CYCLES + DEBOUNCE_CYCLES + 3 cycles.
//   Reset mid-operation: immediate return to reset values. A pending press never produces a pulse.
// CONFIGURATION
//   KEYPAD_BIP_EN defined:
//     - key_bip goes 1 on the same edge as key_valid and stays 1 for BIP_CYCLES cycles.
//     - A new key during an active bip restarts the count.
//   KEYPAD_BIP_EN undefined:
//     - key_bip tied to 0; bip counter not synthesised.
// TESTING (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8, BIP_CYCLES=5)
//   1. rst=0 then release, row_in=4'hF for 100 cycles -> key_valid never 1, key_code=0,
//      col_out cycles 1110,1101,1011,0111 every 4 cycles.
//   2. Hold '5' (row1 low while col1 driven) 40 cycles -> exactly one key_valid, key_code=4'h5;
//      with KEYPAD_BIP_EN key_bip=1 for exactly 5 cycles.
//   3. '*' row3 toggles every 3 cycles for 30 cycles, then stable 20 -> no pulse while bouncing,
//      then one pulse key_code=4'hE.
//   4. Row0 and row2 low together on col2 for 50 cycles -> no key_valid; scanning continues.
//   5. Hold '#' 500 cycles, release 20, press '0' -> two pulses total, codes 4'hF then 4'h0.
//   6. Press 'D', assert rst at debounce count 4 -> outputs at reset values, no pulse ever
//      for that press.

Source files
------------

// File: rtl/teclado_matricial_if.sv
// Keypad scanner bus: matrix lines, accepted-key outputs and a state debug tap.
// The master side is the scanner; the slave side is the keypad/consumer.
interface teclado_matricial_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_bip;
    logic [1:0] state_dbg;

    // key_valid is a one-cycle qualifier for key_code; there is no ready, the consumer must take it.
    modport master (
        input  row_in,
        output col_out,
        output key_valid,
        output key_code,
        output key_bip,
        output state_dbg
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_valid,
        input  key_code,
        input  key_bip,
        input  state_dbg
    );
endinterface

// File: rtl/teclado_matricial.sv
// 4x4 matrix keypad scanner with row synchroniser, press/release debounce and one pulse per press.
// Optional feedback pulse on key_bip when KEYPAD_BIP_EN is defined.
module teclado_matricial #(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BIP_CYCLES      = 5000000
) (
    input  logic                 clk,
    input  logic                 rst,
    teclado_matricial_if.master  kp
);

    localparam int MAX_SD = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int MAX_P  = (MAX_SD > BIP_CYCLES) ? MAX_SD : BIP_CYCLES;
    localparam int CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] deb_q, deb_d;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    rows_s_q, rows_s_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;

    logic [2:0]    row_hit;
    logic [3:0]    row_pattern;

    // Returns {valid, row index}; valid only when exactly one row is pulled low.
    function automatic logic [2:0] decode_row(input logic [3:0] rows);
        case (rows)
            4'b1110: decode_row = {1'b1, 2'd0};
            4'b1101: decode_row = {1'b1, 2'd1};
            4'b1011: decode_row = {1'b1, 2'd2};
            4'b0111: decode_row = {1'b1, 2'd3};
            default: decode_row = 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: map_key = 4'h1;
            4'h1: map_key = 4'h2;
            4'h2: map_key = 4'h3;
            4'h3: map_key = 4'hA;
            4'h4: map_key = 4'h4;
            4'h5: map_key = 4'h5;
            4'h6: map_key = 4'h6;
            4'h7: map_key = 4'hB;
            4'h8: map_key = 4'h7;
            4'h9: map_key = 4'h8;
            4'hA: map_key = 4'h9;
            4'hB: map_key = 4'hC;
            4'hC: map_key = 4'hE;
            4'hD: map_key = 4'h0;
            4'hE: map_key = 4'hF;
            default: map_key = 4'hD;
        endcase
    endfunction

    assign row_hit     = decode_row(rows_s_q);
    assign row_pattern = ~(4'b0001 << row_q);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        dwell_d     = dwell_q;
        deb_d       = deb_q;
        sync1_d     = kp.row_in;
        rows_s_d    = sync1_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;

        case (state_q)
            S_SCAN: begin
                if (dwell_q == SCAN_LAST) begin
                    dwell_d = '0;
                    if (row_hit[2]) begin
                        row_d   = row_hit[1:0];
                        deb_d   = '0;
                        state_d = S_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            S_DEBOUNCE: begin
                if (rows_s_q == row_pattern) begin
                    if (deb_q == DEB_LAST) begin
                        key_valid_d = 1'b1;
                        key_code_d  = map_key(row_q, col_q);
                        deb_d       = '0;
                        state_d     = S_HELD;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    col_d   = col_q + 2'd1;
                    dwell_d = '0;
                    state_d = S_SCAN;
                end
            end
            S_HELD: begin
                // Only the held column is driven, so keys on other columns are invisible here.
                if (rows_s_q == 4'hF) begin
                    if (deb_q == DEB_LAST) begin
                        deb_d   = '0;
                        dwell_d = '0;
                        col_d   = col_q + 2'd1;
                        state_d = S_SCAN;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    deb_d = '0;
                end
            end
            default: begin
                state_d = S_SCAN;
                dwell_d = '0;
                deb_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_SCAN;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            dwell_q     <= '0;
            deb_q       <= '0;
            sync1_q     <= 4'hF;
            rows_s_q    <= 4'hF;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            sync1_q     <= sync1_d;
            rows_s_q    <= rows_s_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

`ifdef KEYPAD_BIP_EN
    localparam logic [CW-1:0] BIP_LAST = CW'(BIP_CYCLES - 1);

    logic          bip_q, bip_d;
    logic [CW-1:0] bip_cnt_q, bip_cnt_d;

    always_comb begin
        bip_d     = bip_q;
        bip_cnt_d = bip_cnt_q;
        if (key_valid_d) begin
            bip_d     = 1'b1;
            bip_cnt_d = '0;
        end else if (bip_q) begin
            if (bip_cnt_q == BIP_LAST) begin
                bip_d = 1'b0;
            end else begin
                bip_cnt_d = bip_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bip_q     <= 1'b0;
            bip_cnt_q <= '0;
        end else begin
            bip_q     <= bip_d;
            bip_cnt_q <= bip_cnt_d;
        end
    end

    assign kp.key_bip = bip_q;
`else
    assign kp.key_bip = 1'b0;
`endif

    assign kp.col_out   = ~(4'b0001 << col_q);
    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;
    assign kp.state_dbg = state_q;

endmodule
